division_reconstructor: RTL and testbench

- Sequential shift-add engine computing quotient*divisor + remainder, the inverse of the non-restoring divider; it rebuilds the dividend from the divider's outputs.
- Sits beside the divider top level and consumes its quotient/remainder buses plus the original divisor.
- Used for on-chip self-check and bench scoreboarding.
- Same start/done handshake style as the divider.

---
 rtl/division_reconstructor_pkg.sv | 15 +
 rtl/division_reconstructor_controlpath.sv | 81 ++++++++
 rtl/division_reconstructor.sv | 119 +++++++++++
 tb/tb_division_reconstructor.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/division_reconstructor_pkg.sv
// Shared widths and state encoding for the division reconstructor (quotient*divisor + remainder).
package division_reconstructor_pkg;

   localparam int DR_WIDTH = 16;
   localparam int DR_REM_W = DR_WIDTH + 1;
   localparam int DR_RES_W = 2 * DR_WIDTH + 1;
   localparam int DR_CNT_W = $clog2(DR_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } dr_state_e;

endpackage

// File: rtl/division_reconstructor_controlpath.sv
// Control path of the division reconstructor: IDLE/RUN/DONE FSM, iteration counter,
// registered busy/done, and load/iterate enables for the datapath held in the top.
module division_reconstructor_controlpath
   import division_reconstructor_pkg::*;
#(
   parameter int WIDTH = DR_WIDTH
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_start,
   output logic o_load,
   output logic o_iter,
   output logic o_last,
   output logic o_busy,
   output logic o_done
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   dr_state_e        r_state;
   logic [CNT_W-1:0] r_count;
   logic             r_busy;
   logic             r_done;

   assign o_load = (r_state == ST_IDLE) && i_start;
   assign o_iter = (r_state == ST_RUN);
   assign o_last = (r_state == ST_RUN) && (r_count == CNT_LAST);
   assign o_busy = r_busy;
   assign o_done = r_done;

   // FSM with busy/done registered alongside the state they decode
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_count <= '0;
               r_done  <= 1'b0;
               if (i_start) begin
                  r_state <= ST_RUN;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (r_count == CNT_LAST) begin
                  r_state <= ST_DONE;
                  r_count <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= ST_RUN;
                  r_count <= r_count + CNT_W'(1);
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_count <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_count <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/division_reconstructor.sv
// Shift-add engine rebuilding dividend = quotient*divisor + remainder in WIDTH fixed iterations.
// Optional self-check ports are enabled by DIVISION_RECONSTRUCT_CHECK_EN.
module division_reconstructor
   import division_reconstructor_pkg::*;
#(
   parameter int WIDTH = DR_WIDTH
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [WIDTH-1:0]     i_quotient,
   input  logic [WIDTH-1:0]     i_divisor,
   input  logic [WIDTH:0]       i_remainder,
   output logic [2*WIDTH:0]     o_result,
   output logic                 o_busy,
   output logic                 o_done
`ifdef DIVISION_RECONSTRUCT_CHECK_EN
   ,
   input  logic [WIDTH-1:0]     i_expected_dividend,
   output logic                 o_match,
   output logic                 o_check_valid
`endif
);

   localparam int REM_W = WIDTH + 1;
   localparam int RES_W = 2 * WIDTH + 1;

   logic             w_load;
   logic             w_iter;
   logic             w_last;
   logic [RES_W-1:0] w_acc_next;
   logic [RES_W-1:0] r_mcand;
   logic [RES_W-1:0] r_acc;
   logic [RES_W-1:0] r_result;
   logic [WIDTH-1:0] r_mplier;

   division_reconstructor_controlpath #(
      .WIDTH (WIDTH)
   ) u_ctrl (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (i_start),
      .o_load  (w_load),
      .o_iter  (w_iter),
      .o_last  (w_last),
      .o_busy  (o_busy),
      .o_done  (o_done)
   );

   // Conditional add of the shifted multiplicand for the current multiplier bit
   always_comb begin
      w_acc_next = r_acc;
      if (r_mplier[0]) begin
         w_acc_next = r_acc + r_mcand;
      end else begin
         w_acc_next = r_acc;
      end
   end

   // Operand capture, iteration registers and held result
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_result <= '0;
      end else if (w_load) begin
         r_mcand  <= {{(WIDTH + 1){1'b0}}, i_divisor};
         r_mplier <= i_quotient;
         r_acc    <= {{WIDTH{1'b0}}, i_remainder};
      end else if (w_iter) begin
         r_acc    <= w_acc_next;
         r_mcand  <= {r_mcand[RES_W-2:0], 1'b0};
         r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
         if (w_last) begin
            r_result <= w_acc_next;
         end
      end
   end

   assign o_result = r_result;

`ifdef DIVISION_RECONSTRUCT_CHECK_EN
   logic [WIDTH-1:0] r_exp_cap;
   logic [WIDTH-1:0] r_div_cap;
   logic [REM_W-1:0] r_rem_cap;
   logic             r_match;
   logic             r_check_valid;
   logic             w_match;

   // A valid remainder must also be strictly below the divisor
   assign w_match = (w_acc_next == {{(WIDTH + 1){1'b0}}, r_exp_cap})
                 && (r_rem_cap < {1'b0, r_div_cap});

   // Capture check operands at start; evaluate on the completing iteration
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_exp_cap     <= '0;
         r_div_cap     <= '0;
         r_rem_cap     <= '0;
         r_match       <= 1'b0;
         r_check_valid <= 1'b0;
      end else begin
         r_check_valid <= w_last;
         if (w_load) begin
            r_exp_cap <= i_expected_dividend;
            r_div_cap <= i_divisor;
            r_rem_cap <= i_remainder;
         end else if (w_last) begin
            r_match   <= w_match;
         end
      end
   end

   assign o_match       = r_match;
   assign o_check_valid = r_check_valid;
`endif

endmodule

// File: tb/tb_division_reconstructor.sv
// Directed bench for division_reconstructor; check ports exercised when DIVISION_RECONSTRUCT_CHECK_EN is defined.
module tb_division_reconstructor;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] quotient;
   logic [15:0] divisor;
   logic [16:0] remainder;
   logic [32:0] result;
   logic        busy;
   logic        done;
   logic [15:0] exp_div;
`ifdef DIVISION_RECONSTRUCT_CHECK_EN
   logic        match;
   logic        check_valid;
`endif

   int          n_vec;
   int          n_err;
   logic [32:0] prev_result;

   division_reconstructor #(.WIDTH(16)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_quotient  (quotient),
      .i_divisor   (divisor),
      .i_remainder (remainder),
      .o_result    (result),
      .o_busy      (busy),
      .o_done      (done)
`ifdef DIVISION_RECONSTRUCT_CHECK_EN
      ,
      .i_expected_dividend (exp_div),
      .o_match             (match),
      .o_check_valid       (check_valid)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One complete operation: checks latency, busy length, result, one-cycle done, hold
   task automatic run_op(input string tag, input logic [15:0] q, input logic [15:0] d,
                         input logic [16:0] r, input logic [15:0] ed,
                         input logic [32:0] exp_res, input logic exp_match);
      int k;
      int busy_n;
      bit seen;
      @(negedge clk);
      quotient  = q;
      divisor   = d;
      remainder = r;
      exp_div   = ed;
      start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start     = 1'b0;
      quotient  = ~q;
      divisor   = ~d;
      remainder = ~r;
      exp_div   = ~ed;
      chk({tag, "_held_at_start"}, {31'd0, result}, {31'd0, prev_result});
      k = 1;
      busy_n = 0;
      seen = 1'b0;
      while (k <= 40 && !seen) begin
         if (busy) busy_n++;
         if (done) begin
            seen = 1'b1;
         end else begin
            @(negedge clk);
            k++;
         end
      end
      chk({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
      chk({tag, "_latency"}, k - 1, 64'd16);
      chk({tag, "_busy_cycles"}, busy_n, 64'd16);
      chk({tag, "_result"}, {31'd0, result}, {31'd0, exp_res});
`ifdef DIVISION_RECONSTRUCT_CHECK_EN
      chk({tag, "_check_valid"}, {63'd0, check_valid}, 64'd1);
      chk({tag, "_match"}, {63'd0, match}, {63'd0, exp_match});
`endif
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
      chk({tag, "_result_hold"}, {31'd0, result}, {31'd0, exp_res});
`ifdef DIVISION_RECONSTRUCT_CHECK_EN
      chk({tag, "_check_valid_drop"}, {63'd0, check_valid}, 64'd0);
      chk({tag, "_match_hold"}, {63'd0, match}, {63'd0, exp_match});
`else
      if (exp_match !== exp_match) n_err++;
`endif
      prev_result = exp_res;
   endtask

   initial begin
      int first_done;
      int second_done;
      int n_done;
      n_vec       = 0;
      n_err       = 0;
      prev_result = 33'd0;
      rst         = 1'b0;
      start       = 1'b0;
      quotient    = 16'd0;
      divisor     = 16'd0;
      remainder   = 17'd0;
      exp_div     = 16'd0;
      repeat (3) @(negedge clk);
      chk("reset_result", {31'd0, result}, 64'd0);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);
      rst = 1'b1;
      @(negedge clk);

      run_op("t1_small", 16'h0003, 16'h0005, 17'h00002, 16'h0011, 33'h0_0000_0011, 1'b1);
      run_op("t2_max", 16'hFFFF, 16'hFFFF, 17'h1FFFF, 16'h0000, 33'h1_0000_0000, 1'b0);
      run_op("t3_div0", 16'h1234, 16'h0000, 17'h00007, 16'h0007, 33'h0_0000_0007, 1'b0);
      run_op("t3_rem0", 16'hABCD, 16'h0001, 17'h00000, 16'hABCD, 33'h0_0000_ABCD, 1'b1);

      // Asynchronous reset in the middle of an operation
      @(negedge clk);
      quotient  = 16'h00FF;
      divisor   = 16'h00FF;
      remainder = 17'h00001;
      start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("t4_async_result", {31'd0, result}, 64'd0);
      chk("t4_async_busy", {63'd0, busy}, 64'd0);
      chk("t4_async_done", {63'd0, done}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      prev_result = 33'd0;
      run_op("t4_after_rst", 16'h0003, 16'h0005, 17'h00002, 16'h0011, 33'h0_0000_0011, 1'b1);

      // start held high: back-to-back ops, operands scrambled mid-RUN
      @(negedge clk);
      quotient    = 16'h0003;
      divisor     = 16'h0005;
      remainder   = 17'h00002;
      start       = 1'b1;
      first_done  = 0;
      second_done = 0;
      n_done      = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done) begin
            n_done++;
            if (first_done == 0) first_done = k;
            else if (second_done == 0) second_done = k;
         end
         if (k == 5 || k == 22) begin
            quotient  = 16'hFFFF;
            divisor   = 16'hFFFF;
            remainder = 17'h1FFFF;
         end
         if (k == 17) begin
            chk("t5_first_result", {31'd0, result}, 64'h11);
            quotient  = 16'h0100;
            divisor   = 16'h0010;
            remainder = 17'h00005;
         end
         if (k == 35) begin
            chk("t5_second_result", {31'd0, result}, 64'h1005);
            start = 1'b0;
         end
      end
      chk("t5_first_done_pos", first_done, 64'd17);
      chk("t5_second_done_pos", second_done, 64'd35);
      chk("t5_done_pulses", n_done, 64'd2);
      chk("t5_idle_after", {63'd0, busy}, 64'd0);
      prev_result = 33'h0_0000_1005;

`ifdef DIVISION_RECONSTRUCT_CHECK_EN
      run_op("t6_match", 16'd14, 16'd7, 17'd2, 16'd100, 33'd100, 1'b1);
      run_op("t6_badrem", 16'd13, 16'd7, 17'd9, 16'd100, 33'd100, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
